// File: rtl/mips8_pc_seq.sv
// mips8_pc_seq: registered program-counter sequencer for the 8-bit
// single-cycle MIPS core. It drives the core's pc with start/halt control,
// taken branches, an end-of-program stop and a retired-instruction counter.
//
// Build option: define MIPS8_PC_STEP_EN to add the single-step (STEP)
// state. Without it the step input is ignored and state never reads 3.
module mips8_pc_seq #(
    parameter logic [7:0] PC_RESET = 8'd0,
    parameter logic [7:0] PC_LAST  = 8'd20,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic             step,
    input  logic             br_taken,
    input  logic [7:0]       br_target,
    output logic [7:0]       pc,
    output logic             pc_valid,
    output logic             done,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    // State encodings are visible on the state port, so they are fixed values.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_HALT = 3'd2;
`ifdef MIPS8_PC_STEP_EN
    localparam logic [2:0] S_STEP = 3'd3;
`endif
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       r_state;
    logic [7:0]       r_pc;
    logic             r_pc_valid;
    logic             r_done;
    logic [CNT_W-1:0] r_retired;

    logic [2:0]       w_next_state;
    logic [7:0]       w_adv_pc;
    logic             w_at_end;
    logic             w_restart;

`ifndef MIPS8_PC_STEP_EN
    // Single-step is compiled out; the input is deliberately left unused.
    logic w_step_unused;
    assign w_step_unused = step;
`endif

    // Next-PC for an executing cycle: branch, hold at the last address, or
    // increment with natural 8-bit wrap-around.
    assign w_adv_pc = br_taken          ? br_target :
                      (r_pc == PC_LAST) ? r_pc      :
                                          r_pc + 8'd1;

    // The executing instruction is the last one and does not branch away.
    assign w_at_end = (r_pc == PC_LAST) && !br_taken;

    // A start from IDLE or DONE begins a fresh run at PC_RESET.
    assign w_restart = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Next-state decode for the sequencer FSM.
    always_comb begin
        // NOTE: default first so every path assigns w_next_state; otherwise
        // a missed branch would infer a latch.
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (w_at_end)      w_next_state = S_DONE;
                else if (halt_req) w_next_state = S_HALT;
            end
            S_HALT: begin
                if (start) w_next_state = S_RUN;
`ifdef MIPS8_PC_STEP_EN
                else if (step) w_next_state = S_STEP;
`endif
            end
`ifdef MIPS8_PC_STEP_EN
            S_STEP: begin
                w_next_state = w_at_end ? S_DONE : S_HALT;
            end
`endif
            S_DONE: begin
                if (start) w_next_state = S_RUN;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, status flags, pc and retired counter; reset overrides everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= PC_RESET;
            r_pc_valid <= 1'b0;
            r_done     <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_state <= w_next_state;
`ifdef MIPS8_PC_STEP_EN
            r_pc_valid <= (w_next_state == S_RUN) || (w_next_state == S_STEP);
`else
            r_pc_valid <= (w_next_state == S_RUN);
`endif
            r_done <= (w_next_state == S_DONE);

            // Branch inputs only matter while an instruction is executing.
            if (r_pc_valid) begin
                r_pc <= w_adv_pc;
            end else if (w_restart) begin
                r_pc <= PC_RESET;
            end

            // Counter saturates at all-ones instead of wrapping.
            if (w_restart) begin
                r_retired <= '0;
            end else if (r_pc_valid && (r_retired != {CNT_W{1'b1}})) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign pc       = r_pc;
    assign pc_valid = r_pc_valid;
    assign done     = r_done;
    assign state    = r_state;
    assign retired  = r_retired;

endmodule

// File: tb/tb_mips8_pc_seq.sv
// Testbench for mips8_pc_seq. Stimulus pushes the expected (pc, retired)
// pair of every executed instruction into a queue; a monitor pops and
// compares on each cycle where the DUT shows pc_valid. Status registers
// (state, done, held pc) are checked directly at the points of interest.
// A second instance with PC_LAST=2 and a 3-bit counter covers wrap-around
// and counter saturation.
module tb_mips8_pc_seq;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ret;
    } exp_t;

    logic        clk = 1'b0;
    // Main instance signals
    logic        reset = 1'b1, start = 1'b0, halt_req = 1'b0, step = 1'b0;
    logic        br_taken = 1'b0;
    logic [7:0]  br_target = 8'h00;
    logic [7:0]  pc;
    logic        pc_valid, done;
    logic [2:0]  state;
    logic [15:0] retired;
    // Wrap-around instance signals
    logic        reset2 = 1'b1, start2 = 1'b0, br_taken2 = 1'b0;
    logic [7:0]  br_target2 = 8'h00;
    logic [7:0]  pc2;
    logic        pc_valid2, done2;
    logic [2:0]  state2;
    logic [2:0]  retired2;

    exp_t q_main[$];
    exp_t q_wrap[$];
    exp_t e_main, e_wrap;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mips8_pc_seq u_dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .step(step), .br_taken(br_taken), .br_target(br_target),
        .pc(pc), .pc_valid(pc_valid), .done(done), .state(state),
        .retired(retired)
    );

    mips8_pc_seq #(.PC_RESET(8'd0), .PC_LAST(8'h02), .CNT_W(3)) u_wrap (
        .clk(clk), .reset(reset2), .start(start2), .halt_req(1'b0),
        .step(1'b0), .br_taken(br_taken2), .br_target(br_target2),
        .pc(pc2), .pc_valid(pc_valid2), .done(done2), .state(state2),
        .retired(retired2)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_main(input logic [7:0] p, input int r);
        exp_t e;
        e.pc  = p;
        e.ret = 16'(r);
        q_main.push_back(e);
    endtask

    task automatic push_wrap(input logic [7:0] p, input int r);
        exp_t e;
        e.pc  = p;
        e.ret = 16'(r);
        q_wrap.push_back(e);
    endtask

    // Expected run of consecutive pcs with consecutive retired counts.
    task automatic push_seq(input int from, input int to, input int r0);
        for (int i = from; i <= to; i++) push_main(8'(i), r0 + (i - from));
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_pc(input logic [7:0] t);
        int n;
        n = 0;
        while (!(pc == t && pc_valid) && n < 100) begin
            tick;
            n++;
        end
        if (n >= 100) check("wait_pc_timeout", 32'(pc), 32'(t));
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while (!done && n < 100) begin
            tick;
            n++;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    // Scoreboard monitors: compare each executed instruction away from the edge.
    always @(negedge clk) begin
        if (pc_valid) begin
            if (q_main.size() == 0) begin
                check("main_unexpected_valid", 32'(pc), 32'hFFFF_FFFF);
            end else begin
                e_main = q_main.pop_front();
                check("main_pc", 32'(pc), 32'(e_main.pc));
                check("main_retired", 32'(retired), 32'(e_main.ret));
            end
        end
    end

    always @(negedge clk) begin
        if (pc_valid2) begin
            if (q_wrap.size() == 0) begin
                check("wrap_unexpected_valid", 32'(pc2), 32'hFFFF_FFFF);
            end else begin
                e_wrap = q_wrap.pop_front();
                check("wrap_pc", 32'(pc2), 32'(e_wrap.pc));
                check("wrap_retired", 32'(retired2), 32'(e_wrap.ret));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset for two cycles.
        tick;
        tick;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_valid", 32'(pc_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst2_state", 32'(state2), 32'd0);
        reset  = 1'b0;
        reset2 = 1'b0;

        // halt_req/step ignored in IDLE.
        halt_req = 1'b1;
        step     = 1'b1;
        tick;
        halt_req = 1'b0;
        step     = 1'b0;
        tick;
        check("idle_ignores_state", 32'(state), 32'd0);

        // Plain run 0..20, then DONE.
        push_seq(0, 20, 0);
        pulse_start;
        check("start_state_run", 32'(state), 32'd1);
        wait_done;
        check("run_done_state", 32'(state), 32'd4);
        check("run_retired", 32'(retired), 32'd21);
        tick;
        tick;
        check("done_holds_pc", 32'(pc), 32'd20);
        check("done_valid_low", 32'(pc_valid), 32'd0);

        // Branch at 5 to 0x10, then branch at 20 to 3 prevents DONE.
        push_seq(0, 5, 0);
        push_seq(16, 20, 6);
        push_seq(3, 20, 11);
        pulse_start;
        check("restart_done_low", 32'(done), 32'd0);
        wait_pc(8'd5);
        br_taken  = 1'b1;
        br_target = 8'h10;
        tick;
        br_taken = 1'b0;
        wait_pc(8'd20);
        br_taken  = 1'b1;
        br_target = 8'd3;
        tick;
        br_taken = 1'b0;
        check("branch_last_state", 32'(state), 32'd1);
        check("branch_last_pc", 32'(pc), 32'd3);
        wait_done;
        check("branch_retired", 32'(retired), 32'd29);

        // Halt at 7, resume with simultaneous start+halt_req (start wins).
        push_seq(0, 7, 0);
        pulse_start;
        wait_pc(8'd7);
        halt_req = 1'b1;
        tick;
        halt_req = 1'b0;
        check("halt_state", 32'(state), 32'd2);
        check("halt_pc", 32'(pc), 32'd8);
        check("halt_valid", 32'(pc_valid), 32'd0);
        check("halt_retired", 32'(retired), 32'd8);
        tick;
        tick;
        check("halt_holds_pc", 32'(pc), 32'd8);
        push_seq(8, 20, 8);
        start    = 1'b1;
        halt_req = 1'b1;
        tick;
        start    = 1'b0;
        halt_req = 1'b0;
        check("resume_state", 32'(state), 32'd1);
        tick;
        check("halt_dropped_state", 32'(state), 32'd1);
        wait_done;
        check("resume_retired", 32'(retired), 32'd21);

        // Single step from HALT at pc 5.
        push_seq(0, 4, 0);
        pulse_start;
        wait_pc(8'd4);
        halt_req = 1'b1;
        tick;
        halt_req = 1'b0;
        check("step_halt_pc", 32'(pc), 32'd5);
`ifdef MIPS8_PC_STEP_EN
        push_main(8'd5, 5);
        step = 1'b1;
        tick;
        step = 1'b0;
        check("step1_state", 32'(state), 32'd3);
        tick;
        check("step1_back_halt", 32'(state), 32'd2);
        check("step1_pc", 32'(pc), 32'd6);
        push_main(8'd6, 6);
        step = 1'b1;
        tick;
        step = 1'b0;
        tick;
        check("step2_state", 32'(state), 32'd2);
        check("step2_pc", 32'(pc), 32'd7);
        check("step2_retired", 32'(retired), 32'd7);
        push_seq(7, 20, 7);
`else
        step = 1'b1;
        tick;
        step = 1'b0;
        check("nostep_state", 32'(state), 32'd2);
        tick;
        check("nostep_pc", 32'(pc), 32'd5);
        check("nostep_retired", 32'(retired), 32'd5);
        push_seq(5, 20, 5);
`endif
        pulse_start;
        wait_done;
        check("step_final_retired", 32'(retired), 32'd21);

        // Reset mid-run together with a taken branch.
        push_seq(0, 9, 0);
        pulse_start;
        wait_pc(8'd9);
        reset     = 1'b1;
        br_taken  = 1'b1;
        br_target = 8'h33;
        tick;
        reset    = 1'b0;
        br_taken = 1'b0;
        check("midrst_pc", 32'(pc), 32'd0);
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_retired", 32'(retired), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        tick;
        check("midrst_idle_pc", 32'(pc), 32'd0);
        check("main_queue_empty", 32'(q_main.size()), 32'd0);

        // Wrap-around and 3-bit counter saturation on the PC_LAST=2 instance.
        push_wrap(8'h00, 0);
        push_wrap(8'hFE, 1);
        push_wrap(8'hFF, 2);
        push_wrap(8'h00, 3);
        push_wrap(8'hFE, 4);
        push_wrap(8'hFF, 5);
        push_wrap(8'h00, 6);
        push_wrap(8'h01, 7);
        push_wrap(8'h02, 7);
        start2 = 1'b1;
        tick;
        start2     = 1'b0;
        br_taken2  = 1'b1;
        br_target2 = 8'hFE;
        tick;
        br_taken2 = 1'b0;
        tick;
        tick;
        check("wrap_zero_pc", 32'(pc2), 32'd0);
        br_taken2 = 1'b1;
        tick;
        br_taken2 = 1'b0;
        for (int n = 0; n < 50 && !done2; n++) tick;
        check("wrap_done", 32'(done2), 32'd1);
        check("wrap_state", 32'(state2), 32'd4);
        check("wrap_final_pc", 32'(pc2), 32'd2);
        check("wrap_saturated", 32'(retired2), 32'd7);
        check("wrap_queue_empty", 32'(q_wrap.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
